// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit / logic_unit_arbiter
//  Description : Round-robin sharing of one logic_unit between NREQ
//                requesters over valid/ready request and response channels.
//                Each operation takes IDLE -> EXEC -> RESP, at least three
//                cycles.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// logic_unit: combinational bitwise/shift unit.
//   000 a|b   001 a^b   010 a&b   011 ~a   100 a>>b   101 a<<b
//   110/111 are illegal; z is driven to zero so it never carries X.
// ----------------------------------------------------------------------------
module logic_unit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] z
);

    // Operation decode.
    always_comb begin
        z = '0;
        case (op)
            3'b000:  z = a | b;
            3'b001:  z = a ^ b;
            3'b010:  z = a & b;
            3'b011:  z = ~a;
            3'b100:  z = a >> b;
            3'b101:  z = a << b;
            default: z = '0;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// logic_unit_arbiter
// ----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter  int N    = 8,
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_result,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [IDW:0]   c_nreq = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_last = IDW'(NREQ - 1);

    logic [1:0]     r_state;
    logic [1:0]     w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [2:0]     r_op;
    logic [IDW-1:0] r_id;

    logic [IDW-1:0] w_cand [NREQ];
    logic           w_found;
    logic [IDW-1:0] w_grant;
    logic           w_accept;
    logic [IDW-1:0] w_ptr_next;
    logic [N-1:0]   w_z;
    logic           w_illegal;

    // Candidate k in priority order is (rr_ptr + k) mod NREQ.
    for (genvar gk = 0; gk < NREQ; gk++) begin : g_cand
        logic [IDW:0] w_sum;
        assign w_sum      = {1'b0, r_rr_ptr} + (IDW+1)'(gk);
        assign w_cand[gk] = (w_sum >= c_nreq) ? IDW'(w_sum - c_nreq) : w_sum[IDW-1:0];
    end

    // Round-robin winner: first valid requester starting at rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[w_cand[k]]) begin
                w_found = 1'b1;
                w_grant = w_cand[k];
            end
        end
    end

    // One-hot ready toward the winner, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found && !rst) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept   = |(req_valid & req_ready);
    assign w_ptr_next = (w_grant == c_last) ? '0 : w_grant + IDW'(1);
    assign w_illegal  = (r_op[2:1] == 2'b11);

    logic_unit #(.N(N)) u_unit (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .z  (w_z)
    );

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered valid/busy derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_next;
            rsp_valid <= (w_next == S_RESP);
            busy      <= (w_next != S_IDLE);
        end
    end

    // Request capture, pointer advance and result capture in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_id       <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= req_a[w_grant*N +: N];
                r_b      <= req_b[w_grant*N +: N];
                r_op     <= req_op[w_grant*3 +: 3];
                r_id     <= w_grant;
                r_rr_ptr <= w_ptr_next;
            end
            // Illegal ops never sample the unit; the result is forced to zero.
            if (r_state == S_EXEC) begin
                rsp_result <= w_illegal ? '0 : w_z;
                rsp_err    <= w_illegal;
                rsp_id     <= r_id;
            end
        end
    end

endmodule
`default_nettype wire
